// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: opcode decode, step sequencing,
// and all datapath enables/selects, with mem_ready stalls on every memory access.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:5] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [0:1] PCSource,
  output logic [0:1] ALUSrcB,
  output logic [0:1] OpALU,
  output logic       illegal_op,
  output logic [0:3] state
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEMADR    = 4'd2;
  localparam logic [3:0] MEMRD     = 4'd3;
  localparam logic [3:0] MEMWB     = 4'd4;
  localparam logic [3:0] MEMWR     = 4'd5;
  localparam logic [3:0] EXEC      = 4'd6;
  localparam logic [3:0] RTYPE_WB  = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] JUMP      = 4'd9;
  localparam logic [3:0] ADDI_EXEC = 4'd10;
  localparam logic [3:0] ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [5:0] op;

  assign op    = opcode;
  assign state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    OpALU       = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        OpALU   = 2'b10;
        state_d = RTYPE_WB;
      end
      RTYPE_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        OpALU       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // Writes are suppressed for the whole time reset is held
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the instruction opcode from the IR, sequences FETCH/DECODE/execute/memory/writeback steps, and drives every datapath enable and mux select. Its 2-bit `OpALU` output feeds the ALU control block directly, together with `funct`. Memory accesses wait on a `mem_ready` handshake.

## Interface
- No parameters; the encodings below are fixed.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input [0:5]: IR[31:26]. Sampled only in DECODE and MEMADR.
- `mem_ready` input 1: memory has completed the current read/write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst` output 1 each: datapath controls.
- `PCSource` output [0:1]: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUSrcB` output [0:1]: 00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `OpALU` output [0:1]: 00 = add, 01 = sub (beq), 10 = decode by funct.
- `illegal_op` output 1: one-cycle pulse in DECODE for an unsupported opcode.
- `state` output [0:3]: current state, for debug.

## Operation
- 4-bit state register, encoded FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Codes 12-15 go to FETCH on the next edge.
- Moore outputs decode from `state`. `IRWrite`/`PCWrite` in FETCH are additionally gated by `mem_ready`. Any output not listed for a state is 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpALU=00, PCSource=00.
  - Drives IRWrite=PCWrite=mem_ready.
  - Goes to DECODE when mem_ready=1; otherwise stays.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, OpALU=00.
  - Next state by opcode: 000000→EXEC; 100011 or 101011→MEMADR; 000100→BRANCH; 000010→JUMP; 001000→ADDI_EXEC.
  - Any other opcode: illegal_op=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, OpALU=00. Next MEMRD if opcode=100011, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds (MemWrite stays high) until mem_ready=1, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, OpALU=10. Next RTYPE_WB.
- RTYPE_WB: RegDst=1, RegWrite=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, OpALU=00. Next ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.

## Timing
- Reset:
  - rst_n=0 forces state=FETCH immediately, asynchronously.
  - While rst_n=0, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite and illegal_op are forced 0.
  - The remaining outputs show FETCH values: MemRead=1, ALUSrcB=01, all others 0.
  - Release is synchronous to the next clk edge in practice; the first fetch completes on the first edge with mem_ready=1.
- Reset mid-instruction (e.g. in MEMWR with MemWrite=1) drops all writes in the same cycle. No partial writeback completes afterwards.
- Cycle counts with mem_ready held at 1 (FETCH to the next FETCH):
  - R-type: 4.
  - lw: 5.
  - sw: 4.
  - addi: 4.
  - beq: 3.
  - j: 3.
  - Illegal opcode: 2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- PCWrite asserts exactly once per fetch, regardless of stall length.
- mem_ready is ignored in every other state.

## Test plan
- Reset, then mem_ready=1 with opcode=000000:
  - states go 0,1,6,7,0.
  - OpALU=10 in state 6.
  - RegWrite=1 and RegDst=1 only in state 7.
  - PCWrite=1 only in the first cycle.
- opcode=100011, mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD:
  - FETCH lasts 4 cycles, with IRWrite=PCWrite=1 only in its last cycle.
  - MEMRD lasts 3 cycles.
  - MEMWB has MemtoReg=1.
  - Total 10 cycles.
- opcode=101011: states 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5. RegWrite never asserts.
- opcode=000100, then 000010:
  - BRANCH: PCWriteCond=1, PCSource=01, OpALU=01.
  - JUMP: PCWrite=1, PCSource=10.
  - 3 cycles each.
- opcode=111111: illegal_op=1 for exactly one cycle in DECODE, return to FETCH, and no write-enable asserts.
- rst_n pulsed low during MEMWR with mem_ready=0: MemWrite drops the same cycle, state=0 before the next edge, and the normal fetch resumes after release.
